// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
//
// Contents:
//   WORD_W    - width of one instruction word
//   HDR_BYTES - number of bytes in the word-count header
//   state_t   - loader FSM states
package loader_pkg;

  localparam int WORD_W    = 32;
  localparam int HDR_BYTES = 2;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CHK,
    RUN,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: collects four bytes, MSB first, into one instruction word.
//
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   byte_valid  - a byte is being consumed this cycle
//   byte_data   - the byte
//   flush       - discard any partial word
//   word_next   - combinational: this cycle's byte completes a word
//   word_valid  - one-cycle strobe, the cycle after the 4th byte
//   word_data   - the completed word, valid while word_valid is high
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              flush,
  output logic              word_next,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              word_valid_q, word_valid_d;

  assign word_next  = byte_valid && !flush && (idx_q == 2'd3);
  assign word_valid = word_valid_q;
  assign word_data  = shreg_q;

  always_comb begin
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    word_valid_d = 1'b0;
    if (flush) begin
      idx_d   = 2'd0;
      shreg_d = '0;
    end else if (byte_valid) begin
      // Shift left so the first byte of the word ends up in the top byte.
      shreg_d      = {shreg_q[WORD_W-9:0], byte_data};
      idx_d        = idx_q + 2'd1;
      word_valid_d = (idx_q == 2'd3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= 2'd0;
      shreg_q      <= '0;
      word_valid_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      word_valid_q <= word_valid_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream (2-byte word count N, then N words
// MSB first), writes the words sequentially into instruction memory and
// holds the datapath in reset until the whole image has been written.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a 1-byte checksum follows the image; the core is only
//   released if the mod-256 sum of every byte including the checksum is 0.
//
// Ports:
//   clk          - clock
//   reset        - asynchronous active-low reset
//   in_valid     - upstream byte present
//   in_data      - upstream byte
//   in_ready     - loader can accept a byte
//   im_we        - one-cycle instruction memory write strobe
//   im_addr      - byte address of the write (word index * 4)
//   im_wdata     - instruction word being written
//   core_reset   - active-high reset for the datapath
//   done         - image loaded, core running
//   error        - load failed (sticky until reset)
//   words_loaded - number of words written so far
module imem_loader
  import loader_pkg::*;
#(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             im_we,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_wdata,
  output logic             core_reset,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_IMAGE = CHK;
`else
  localparam state_t AFTER_IMAGE = RUN;
`endif

  state_t                   state_q, state_d;
  logic [7:0]               hdr_hi_q, hdr_hi_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [CNT_W-1:0]         words_q, words_d;
  logic [31:0]              addr_q, addr_d;
  logic [HDR_BYTES*8-1:0]   hdr_word;
  logic                     accept;
  logic                     pack_valid;
  logic                     flush;
  logic                     word_next;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]               sum_q, sum_d;
`endif

  // Gating with reset keeps in_ready low while reset is held, even though
  // the state register already sits at HDR_HI.
  assign in_ready = reset && ((state_q == HDR_HI) || (state_q == HDR_LO) ||
                              (state_q == DATA)   || (state_q == CHK));
  assign accept     = in_valid && in_ready;
  assign hdr_word   = {hdr_hi_q, in_data};
  assign pack_valid = accept && (state_q == DATA);
  assign flush      = (state_q != DATA);

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (reset),
    .byte_valid (pack_valid),
    .byte_data  (in_data),
    .flush      (flush),
    .word_next  (word_next),
    .word_valid (im_we),
    .word_data  (im_wdata)
  );

  assign im_addr      = addr_q;
  assign words_loaded = words_q;
  // The final write may land in the first RUN cycle; the core is released
  // only once that write has completed.
  assign core_reset   = !((state_q == RUN) && !im_we);
  assign done         = !core_reset;
  assign error        = (state_q == ERR);

  // Next-state logic: header capture, word counting and address generation.
  always_comb begin
    state_d  = state_q;
    hdr_hi_d = hdr_hi_q;
    count_d  = count_q;
    words_d  = words_q;
    addr_d   = addr_q;
    case (state_q)
      HDR_HI: begin
        if (accept) begin
          hdr_hi_d = in_data;
          state_d  = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          count_d = CNT_W'(hdr_word);
          if (hdr_word == '0) begin
            state_d = AFTER_IMAGE;
          end else if (32'(hdr_word) > 32'(MAX_WORDS)) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_next) begin
          words_d = words_q + CNT_W'(1);
          addr_d  = 32'({words_q, 2'b00});
          if (words_q + CNT_W'(1) == count_q) begin
            state_d = AFTER_IMAGE;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          state_d = (8'(sum_q + in_data) == 8'd0) ? RUN : ERR;
        end
      end
`endif
      default: begin
      end
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running sum over header and data bytes; the checksum byte itself is
  // folded in only at the comparison.
  always_comb begin
    sum_d = sum_q;
    if (accept && (state_q != CHK)) begin
      sum_d = sum_q + in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= 8'd0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= HDR_HI;
      hdr_hi_q <= 8'd0;
      count_q  <= '0;
      words_q  <= '0;
      addr_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      hdr_hi_q <= hdr_hi_d;
      count_q  <= count_d;
      words_q  <= words_d;
      addr_q   <= addr_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: streams images with several valid patterns and
// compares the observed memory writes and status outputs with a reference
// model that parses the image directly.
module tb_imem_loader;

  localparam int MAXW  = 256;
  localparam int CNT_W = 16;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             im_we;
  logic [31:0]      im_addr;
  logic [31:0]      im_wdata;
  logic             core_reset;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] words_loaded;

  imem_loader #(.MAX_WORDS(MAXW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .core_reset   (core_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: records every memory write, back-to-back strobes and the
  // first cycle the core is released.
  logic [63:0] wr_q[$];
  logic [7:0]  img_q[$];
  int          last_acc;
  int          rel_cyc = -1;
  bit          prev_we = 1'b0;
  bit          dbl_we  = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      if (im_we) begin
        wr_q.push_back({im_addr, im_wdata});
        if (prev_we) dbl_we = 1'b1;
      end
      if (!core_reset && rel_cyc < 0) rel_cyc = cyc;
      prev_we = im_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset    = 1'b0;
    wr_q.delete();
    dbl_we   = 1'b0;
    rel_cyc  = -1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Appends a checksum byte that makes the total sum zero, when compiled in.
  task automatic add_checksum();
    logic [7:0] s;
    s = 8'h00;
    foreach (img_q[i]) s = s + img_q[i];
    if (CK == 1) img_q.push_back(8'h00 - s);
  endtask

  task automatic build_random(input int n);
    img_q.delete();
    img_q.push_back(8'(n >> 8));
    img_q.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) img_q.push_back(8'($urandom_range(0, 255)));
    add_checksum();
  endtask

  // mode 0: valid always high, 1: toggling, 2: random
  task automatic send_stream(input int mode, input string name);
    int idx;
    int guard;
    bit v;
    bit took;
    idx      = 0;
    guard    = 0;
    last_acc = -1;
    while (idx < img_q.size() && guard < 5000) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = v;
      in_data  = img_q[idx];
      took     = v && in_ready;
      if (took) last_acc = cyc + 1;
      @(posedge clk);
      if (took) idx++;
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
    total++;
    if (idx != img_q.size()) begin
      bad++;
      $display("[TB] FAIL %s_stream: accepted=%0d required=%0d", name, idx, img_q.size());
    end
  endtask

  // Loads img_q and checks the outcome against the image's own contents.
  task automatic run_image(input int mode, input string name, input bit fresh);
    int          n;
    bit          exp_run;
    int          exp_words;
    int          exp_rel;
    logic [7:0]  s;
    logic [63:0] exp_q[$];
    if (fresh) do_reset();
    send_stream(mode, name);
    repeat (3) @(negedge clk);

    n = int'(img_q[0]) * 256 + int'(img_q[1]);
    s = 8'h00;
    foreach (img_q[i]) s = s + img_q[i];
    exp_q.delete();
    if (n <= MAXW) begin
      for (int k = 0; k < n; k++) begin
        exp_q.push_back({32'(4 * k), img_q[2 + 4 * k], img_q[3 + 4 * k],
                         img_q[4 + 4 * k], img_q[5 + 4 * k]});
      end
    end
    exp_run   = (n <= MAXW) && ((CK == 0) || (s == 8'h00));
    exp_words = (n <= MAXW) ? n : 0;
    exp_rel   = exp_run ? (last_acc + (((CK == 1) || (n == 0)) ? 0 : 1)) : -1;

    total++;
    if (wr_q.size() !== exp_q.size()) begin
      bad++;
      $display("[TB] FAIL %s_nwrites: actual=%0d required=%0d", name, wr_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
      total++;
      if (wr_q[k] !== exp_q[k]) begin
        bad++;
        $display("[TB] FAIL %s_write%0d: actual=%h required=%h", name, k, wr_q[k], exp_q[k]);
      end
    end
    total++;
    if (done !== exp_run) begin
      bad++;
      $display("[TB] FAIL %s_done: actual=%b required=%b", name, done, exp_run);
    end
    total++;
    if (error !== !exp_run) begin
      bad++;
      $display("[TB] FAIL %s_error: actual=%b required=%b", name, error, !exp_run);
    end
    total++;
    if (core_reset !== !exp_run) begin
      bad++;
      $display("[TB] FAIL %s_core_reset: actual=%b required=%b", name, core_reset, !exp_run);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_in_ready: actual=%b required=0", name, in_ready);
    end
    total++;
    if (words_loaded !== CNT_W'(exp_words)) begin
      bad++;
      $display("[TB] FAIL %s_words: actual=%0d required=%0d", name, words_loaded, exp_words);
    end
    total++;
    if (dbl_we !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_double_we: actual=1 required=0", name);
    end
    total++;
    if (rel_cyc !== exp_rel) begin
      bad++;
      $display("[TB] FAIL %s_release: actual=%0d required=%0d", name, rel_cyc, exp_rel);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    #3;
    total++;
    if ({in_ready, im_we, im_addr, im_wdata, core_reset, done, error, words_loaded} !==
        {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 16'd0}) begin
      bad++;
      $display("[TB] FAIL reset_values: actual=%b%b_%h_%h_%b%b%b_%0d required=00_0_0_100_0",
               in_ready, im_we, im_addr, im_wdata, core_reset, done, error, words_loaded);
    end
    repeat (2) @(negedge clk);
    total++;
    if (words_loaded !== 16'd0) begin
      bad++;
      $display("[TB] FAIL reset_hold_words: actual=%0d required=0", words_loaded);
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_ready: actual=%b required=1", in_ready);
    end
  endtask

  // After RUN, offered bytes must not be taken or written.
  task automatic test_run_ignores();
    int before_words;
    int before_wr;
    before_words = int'(words_loaded);
    before_wr    = wr_q.size();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (int'(words_loaded) !== before_words || wr_q.size() !== before_wr || done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL run_ignores: words=%0d writes=%0d done=%b required=%0d %0d 1",
               words_loaded, wr_q.size(), done, before_words, before_wr);
    end
  endtask

  task automatic test_basic();
    img_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    add_checksum();
    run_image(0, "basic", 1'b1);
    test_run_ignores();
  endtask

  task automatic test_toggle();
    img_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    add_checksum();
    run_image(1, "toggle", 1'b1);
  endtask

  task automatic test_overflow();
    img_q = '{8'h01, 8'h01};
    run_image(0, "overflow", 1'b1);
  endtask

  task automatic test_max_words();
    build_random(MAXW);
    run_image(0, "max_words", 1'b1);
  endtask

  task automatic test_empty();
    img_q = '{8'h00, 8'h00};
    add_checksum();
    run_image(0, "empty", 1'b1);
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    img_q.delete();
    img_q.push_back(8'h00);
    img_q.push_back(8'h03);
    for (int i = 0; i < 6; i++) img_q.push_back(8'($urandom_range(0, 255)));
    send_stream(0, "midload_pre");
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (words_loaded !== 16'd0 || im_we !== 1'b0 || in_ready !== 1'b0 || core_reset !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midload_async: words=%0d we=%b ready=%b core_reset=%b required=0 0 0 1",
               words_loaded, im_we, in_ready, core_reset);
    end
    wr_q.delete();
    dbl_we  = 1'b0;
    rel_cyc = -1;
    @(negedge clk);
    reset = 1'b1;
    img_q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    add_checksum();
    run_image(0, "midload", 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      build_random($urandom_range(1, 8));
      run_image(2, $sformatf("random%0d", t), 1'b1);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    img_q = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFE};
    run_image(0, "checksum_ok", 1'b1);
    img_q = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF};
    run_image(0, "checksum_bad", 1'b1);
  endtask
`endif

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_basic();
    test_toggle();
    test_overflow();
    test_max_words();
    test_empty();
    test_reset_mid_load();
    test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
